// File: rtl/rc4_stream_engine.sv
// RC4 engine: S-box init, key scheduling (KSA) and keystream generation (PRGA)
// over an external synchronous 256x8 S RAM. Each PRGA byte is either XORed with
// the ciphertext ROM byte (decrypt) or written out raw (keystream dump).
module rc4_stream_engine #(
    parameter int unsigned KEY_BYTES = 3,
    parameter int unsigned MSG_LEN   = 32,
    localparam int unsigned AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wdata,
    output logic                   s_we,
    input  logic [7:0]             s_rdata,
    output logic [AW-1:0]          ct_addr,
    input  logic [7:0]             ct_rdata,
    output logic [AW-1:0]          pt_addr,
    output logic [7:0]             pt_wdata,
    output logic                   pt_we
);

    localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA_RI,
        ST_KSA_RJ,
        ST_KSA_WI,
        ST_KSA_WJ,
        ST_PRGA_RI,
        ST_PRGA_RJ,
        ST_PRGA_WI,
        ST_PRGA_WJ,
        ST_PRGA_RK,
        ST_PRGA_OUT,
        ST_DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic                   start_q;
    logic                   accept;
    logic [8*KEY_BYTES-1:0] key_r;
    logic                   mode_r;
    logic [7:0]             i_r;
    logic [7:0]             j_r;
    logic [7:0]             si_r;
    logic [7:0]             sj_r;
    logic [KW-1:0]          kidx;
    logic [AW-1:0]          k_r;

    logic [7:0]             key_byte;
    logic [7:0]             i_inc;
    logic [7:0]             j_ksa;
    logic [7:0]             j_prga;
    logic [7:0]             ks_addr;
    logic                   k_last;
    logic                   kidx_last;

    // Start edge qualification and index arithmetic (all 8-bit, wrapping)
    always_comb begin
        accept    = start && !start_q && (state == ST_IDLE || state == ST_DONE);
        key_byte  = '0;
        for (int unsigned n = 0; n < KEY_BYTES; n++) begin
            if (kidx == KW'(n)) begin
                key_byte = key_r[8*(KEY_BYTES-1-n) +: 8];
            end
        end
        i_inc     = i_r + 8'd1;
        j_ksa     = j_r + s_rdata + key_byte;
        j_prga    = j_r + s_rdata;
        ks_addr   = si_r + sj_r;
        k_last    = (k_r == AW'(MSG_LEN - 1));
        kidx_last = (kidx == KW'(KEY_BYTES - 1));
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and memory-port decode; S read data is consumed the cycle after its address
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        s_we      = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wdata  = '0;
        pt_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (accept) state_nxt = ST_INIT;
            end
            ST_INIT: begin
                s_we    = 1'b1;
                s_addr  = i_r;
                s_wdata = i_r;
                if (i_r == 8'hFF) state_nxt = ST_KSA_RI;
            end
            ST_KSA_RI: begin
                s_addr    = i_r;
                state_nxt = ST_KSA_RJ;
            end
            ST_KSA_RJ: begin
                s_addr    = j_ksa;
                state_nxt = ST_KSA_WI;
            end
            ST_KSA_WI: begin
                s_we      = 1'b1;
                s_addr    = i_r;
                s_wdata   = s_rdata;
                state_nxt = ST_KSA_WJ;
            end
            ST_KSA_WJ: begin
                s_we      = 1'b1;
                s_addr    = j_r;
                s_wdata   = si_r;
                state_nxt = (i_r == 8'hFF) ? ST_PRGA_RI : ST_KSA_RI;
            end
            ST_PRGA_RI: begin
                s_addr    = i_inc;
                state_nxt = ST_PRGA_RJ;
            end
            ST_PRGA_RJ: begin
                s_addr    = j_prga;
                state_nxt = ST_PRGA_WI;
            end
            ST_PRGA_WI: begin
                s_we      = 1'b1;
                s_addr    = i_r;
                s_wdata   = s_rdata;
                state_nxt = ST_PRGA_WJ;
            end
            ST_PRGA_WJ: begin
                s_we      = 1'b1;
                s_addr    = j_r;
                s_wdata   = si_r;
                state_nxt = ST_PRGA_RK;
            end
            ST_PRGA_RK: begin
                s_addr    = ks_addr;
                ct_addr   = k_r;
                state_nxt = ST_PRGA_OUT;
            end
            ST_PRGA_OUT: begin
                pt_we     = 1'b1;
                pt_addr   = k_r;
                pt_wdata  = mode_r ? s_rdata : (s_rdata ^ ct_rdata);
                state_nxt = k_last ? ST_DONE : ST_PRGA_RI;
            end
            ST_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (accept) state_nxt = ST_INIT;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: start history, latched key/mode, RC4 indices and swap operands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q <= 1'b0;
            key_r   <= '0;
            mode_r  <= 1'b0;
            i_r     <= '0;
            j_r     <= '0;
            si_r    <= '0;
            sj_r    <= '0;
            kidx    <= '0;
            k_r     <= '0;
        end else begin
            start_q <= start;
            if (accept) begin
                key_r  <= key;
                mode_r <= mode;
                i_r    <= '0;
            end
            case (state)
                ST_INIT: begin
                    // i wraps 255 -> 0 on the last init write, ready for KSA
                    i_r  <= i_inc;
                    j_r  <= '0;
                    kidx <= '0;
                end
                ST_KSA_RJ: begin
                    si_r <= s_rdata;
                    j_r  <= j_ksa;
                end
                ST_KSA_WJ: begin
                    i_r  <= i_inc;
                    kidx <= kidx_last ? '0 : kidx + 1'b1;
                    if (i_r == 8'hFF) begin
                        j_r <= '0;
                        k_r <= '0;
                    end
                end
                ST_PRGA_RI: begin
                    i_r <= i_inc;
                end
                ST_PRGA_RJ: begin
                    si_r <= s_rdata;
                    j_r  <= j_prga;
                end
                ST_PRGA_WI: begin
                    sj_r <= s_rdata;
                end
                ST_PRGA_OUT: begin
                    k_r <= k_last ? '0 : k_r + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_stream_engine.sv
// Scoreboard bench for rc4_stream_engine using the "Key"/"Plaintext" RC4 vector.
module tb_rc4_stream_engine;

    localparam int unsigned KB = 3;
    localparam int unsigned ML = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [23:0] key;
    logic        busy;
    logic        done;
    logic [7:0]  s_addr;
    logic [7:0]  s_wdata;
    logic        s_we;
    logic [7:0]  s_rdata;
    logic [3:0]  ct_addr;
    logic [7:0]  ct_rdata;
    logic [3:0]  pt_addr;
    logic [7:0]  pt_wdata;
    logic        pt_we;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] smem   [256];
    logic [7:0] ct_rom [16];
    logic [7:0] pt_ref [ML];
    logic [7:0] ks_ref [ML];

    always #5 clk = ~clk;

    rc4_stream_engine #(
        .KEY_BYTES (KB),
        .MSG_LEN   (ML)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .key      (key),
        .busy     (busy),
        .done     (done),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_we     (s_we),
        .s_rdata  (s_rdata),
        .ct_addr  (ct_addr),
        .ct_rdata (ct_rdata),
        .pt_addr  (pt_addr),
        .pt_wdata (pt_wdata),
        .pt_we    (pt_we)
    );

    // Synchronous S RAM and ciphertext ROM models
    always @(posedge clk) begin
        if (s_we) smem[s_addr] <= s_wdata;
        s_rdata  <= smem[s_addr];
        ct_rdata <= ct_rom[ct_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every plaintext write
    always @(negedge clk) begin
        if (reset) begin
            check("we_exclusive", 32'(s_we & pt_we), 32'd0);
            if (pt_we === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pt_write: got addr %0h data %0h expected none",
                             pt_addr, pt_wdata);
                end else begin
                    mon_e = sb.pop_front();
                    check("pt_byte", {20'd0, pt_addr, pt_wdata}, {20'd0, mon_e.addr, mon_e.data});
                end
            end
        end
    end

    task automatic push_exp(input logic m);
        for (int n = 0; n < int'(ML); n++) begin
            exp_t e;
            e.addr = 4'(n);
            e.data = m ? ks_ref[n] : pt_ref[n];
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [71:0] ct_v;
        logic [71:0] pt_v;
        logic [71:0] ks_v;
        int          cnt;
        int          bad;
        int          c;

        ct_v = 72'hBBF316E8D940AF0AD3;
        pt_v = 72'h506C61696E74657874;
        ks_v = 72'hEB9F7781B734CA72A7;
        for (int n = 0; n < 16; n++) ct_rom[n] = 8'h00;
        for (int n = 0; n < int'(ML); n++) begin
            ct_rom[n] = ct_v[8*(8-n) +: 8];
            pt_ref[n] = pt_v[8*(8-n) +: 8];
            ks_ref[n] = ks_v[8*(8-n) +: 8];
        end
        for (int n = 0; n < 256; n++) smem[n] = 8'(n) ^ 8'hA5;

        reset = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        key   = 24'h4B6579;

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", {30'd0, s_we, pt_we}, 32'd0);
        check("rst_addr", {16'd0, s_addr, ct_addr, pt_addr}, 32'd0);
        check("rst_wdata", {16'd0, s_wdata, pt_wdata}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Decrypt
        mode = 1'b0;
        push_exp(1'b0);
        pulse_start();
        check("s1_busy_after_accept", 32'(busy), 32'd1);
        wait_done("s1");

        // Keystream dump
        mode = 1'b1;
        push_exp(1'b1);
        pulse_start();
        wait_done("s2");

        // INIT phase: S[n]==n, 256 consecutive writes; mode/key changed after start must not matter
        mode = 1'b0;
        push_exp(1'b0);
        pulse_start();
        mode = 1'b1;
        key  = 24'h000000;
        cnt  = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (s_we) cnt++;
            else if (cnt > 0) break;
        end
        check("s3_init_we_run", 32'(cnt), 32'd256);
        bad = -1;
        for (int n = 255; n >= 0; n--) if (smem[n] !== 8'(n)) bad = n;
        check("s3_s_identity_first_bad", 32'(bad), 32'hFFFF_FFFF);
        wait_done("s3");
        key  = 24'h4B6579;
        mode = 1'b0;

        // Start held high across completion runs once; fresh edge re-runs
        push_exp(1'b0);
        @(posedge clk);
        #1 start = 1'b1;
        wait_done("s4a");
        repeat (300) @(posedge clk);
        #1;
        check("s4_held_busy", 32'(busy), 32'd0);
        check("s4_held_done", 32'(done), 32'd1);
        start = 1'b0;
        @(posedge clk);
        #1;
        push_exp(1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("s4_accept_done_clr", 32'(done), 32'd0);
        check("s4_accept_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done("s4b");

        // Extra start edge during KSA is ignored
        push_exp(1'b0);
        pulse_start();
        repeat (500) @(posedge clk);
        #1;
        check("s5_busy_mid_ksa", 32'(busy), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("s5");
        repeat (20) @(posedge clk);
        #1;
        check("s5_no_rerun", {30'd0, busy, done}, 32'd1);

        // Reset during PRGA aborts immediately
        push_exp(1'b0);
        pulse_start();
        for (c = 0; c < 3000; c++) begin
            @(posedge clk);
            if (sb.size() < int'(ML)) break;
        end
        check("s6_reached_prga", 32'(sb.size() < int'(ML)), 32'd1);
        #3 reset = 1'b0;
        #1;
        check("s6_abort_busy", 32'(busy), 32'd0);
        check("s6_abort_done", 32'(done), 32'd0);
        check("s6_abort_we", {30'd0, s_we, pt_we}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        push_exp(1'b0);
        pulse_start();
        wait_done("s6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
